// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Instruction fetch stage. Owns the PC, issues word reads to a 1-cycle
//   synchronous instruction memory and presents {instructions, pc} to the
//   decoder. A 1-entry skid buffer absorbs the response already in flight
//   when the decoder stalls. A taken decoder redirect kills all wrong-path
//   fetches.
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   imem_req       read request this cycle
//   imem_addr      read byte address (current fetch PC)
//   imem_rdata     data for the request issued in the previous cycle
//   stall          downstream not accepting; hold the presented instruction
//   next_pc_sel    decoder redirect request
//   target_pc      decoder redirect address
//   instructions   instruction to decoder (NOP when instr_valid=0)
//   pc             address of instructions
//   instr_valid    instructions/pc hold a real, non-killed fetch
module instr_fetch_unit #(
    parameter int                    ADDRR_BITS = 16,
    parameter logic [ADDRR_BITS-1:0] RESET_PC   = '0,
    parameter int                    PC_STEP    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req,
    output logic [ADDRR_BITS-1:0] imem_addr,
    input  logic [31:0]           imem_rdata,
    input  logic                  stall,
    input  logic                  next_pc_sel,
    input  logic [ADDRR_BITS-1:0] target_pc,
    output logic [31:0]           instructions,
    output logic [ADDRR_BITS-1:0] pc,
    output logic                  instr_valid
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    // RUN: skid empty. HELD: skid full, issue blocked.
    // REDIRECT: the response arriving this cycle belongs to a killed request.
    typedef enum logic [1:0] {
        RUN,
        HELD,
        REDIRECT
    } state_t;

    state_t                  state_q, state_d;

    logic [ADDRR_BITS-1:0]   fetch_pc;
    logic                    inflight_q;
    logic [ADDRR_BITS-1:0]   inflight_pc;
    logic                    valid_q;
    logic [31:0]             instr_q;
    logic [ADDRR_BITS-1:0]   pc_q;
    logic [31:0]             skid_instr;
    logic [ADDRR_BITS-1:0]   skid_pc;

    logic                    skid_valid;
    logic                    kill;
    logic                    accept;
    logic                    redirect;
    logic                    resp_ok;
    logic                    load_out;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        if (redirect) begin
            state_d = REDIRECT;
        end else begin
            unique case (state_q)
                RUN:      if (resp_ok && valid_q && stall) state_d = HELD;
                HELD:     if (accept) state_d = RUN;
                REDIRECT: state_d = RUN;
                default:  state_d = RUN;
            endcase
        end
    end

    // ---------------- output / control logic ----------------
    always_comb begin
        skid_valid = (state_q == HELD);
        kill       = (state_q == REDIRECT);
        imem_req   = !stall && !skid_valid;
        accept     = valid_q && !stall;
        redirect   = accept && next_pc_sel;
        resp_ok    = inflight_q && !kill;
        // The output register may take a new value when empty or consumed.
        load_out   = !valid_q || !stall;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            inflight_q  <= 1'b0;
            inflight_pc <= '0;
            valid_q     <= 1'b0;
            instr_q     <= NOP;
            pc_q        <= '0;
            skid_instr  <= '0;
            skid_pc     <= '0;
        end else begin
            // A request issued in a redirect cycle is still tracked; the
            // REDIRECT state discards its response.
            inflight_q <= imem_req;
            if (imem_req) inflight_pc <= fetch_pc;

            if (redirect)      fetch_pc <= target_pc;
            else if (imem_req) fetch_pc <= fetch_pc + ADDRR_BITS'(PC_STEP);

            if (redirect) begin
                // Response arriving now is younger than the branch: drop it.
                valid_q <= 1'b0;
            end else if (load_out) begin
                if (skid_valid) begin
                    valid_q <= 1'b1;
                    instr_q <= skid_instr;
                    pc_q    <= skid_pc;
                end else if (resp_ok) begin
                    valid_q <= 1'b1;
                    instr_q <= imem_rdata;
                    pc_q    <= inflight_pc;
                end else begin
                    valid_q <= 1'b0;
                end
            end else if (resp_ok) begin
                // Stalled with a valid output: park the response in the skid.
                skid_instr <= imem_rdata;
                skid_pc    <= inflight_pc;
            end
        end
    end

    assign imem_addr    = fetch_pc;
    assign instr_valid  = valid_q;
    assign pc           = pc_q;
    assign instructions = valid_q ? instr_q : NOP;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        next_pc_sel;
    logic [15:0] target_pc;
    logic [31:0] instructions;
    logic [15:0] pc;
    logic        instr_valid;

    // second instance for the address-wrap case
    logic        w_req;
    logic [15:0] w_addr;
    logic [31:0] w_rdata;
    logic [31:0] w_instr;
    logic [15:0] w_pc;
    logic        w_valid;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // reference model state
    logic [15:0] exp_pc;
    int          bubbles;
    logic        hold_prev;
    logic [15:0] hold_pc;
    logic [31:0] hold_ins;
    logic        prev_stall;
    int          idle;
    logic [15:0] accepted[$];
    logic        wrap_collect = 1'b0;
    logic [15:0] wrap_pcs[$];

    instr_fetch_unit #(.ADDRR_BITS(16), .RESET_PC(16'h0000), .PC_STEP(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .stall(stall), .next_pc_sel(next_pc_sel),
        .target_pc(target_pc), .instructions(instructions), .pc(pc),
        .instr_valid(instr_valid)
    );

    instr_fetch_unit #(.ADDRR_BITS(16), .RESET_PC(16'hFFF8), .PC_STEP(4)) u_wrap (
        .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
        .imem_rdata(w_rdata), .stall(1'b0), .next_pc_sel(1'b0),
        .target_pc(16'h0000), .instructions(w_instr), .pc(w_pc),
        .instr_valid(w_valid)
    );

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {~a, a};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 1-cycle synchronous instruction memories
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= mem_word(imem_addr);
        if (w_req)    w_rdata    <= mem_word(w_addr);
    end

    always @(negedge clk) begin
        if (wrap_collect && w_valid && wrap_pcs.size() < 4) begin
            wrap_pcs.push_back(w_pc);
            if (w_instr != mem_word(w_pc))
                $display("FAIL wrap_data: got %h expected %h", w_instr, mem_word(w_pc));
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        exp_pc     = 16'h0000;
        bubbles    = 0;
        hold_prev  = 1'b0;
        prev_stall = 1'b0;
        idle       = 0;
        accepted.delete();
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input logic s, input logic sel, input logic [15:0] tgt);
        if (!instr_valid) check("nop", instructions, NOP);
        else              check("data", instructions, mem_word(pc));
        if (hold_prev) begin
            check("hold_v", 32'(instr_valid), 32'd1);
            check("hold_pc", 32'(pc), 32'(hold_pc));
            check("hold_ins", instructions, hold_ins);
        end
        if (bubbles > 0) begin
            check("bubble", 32'(instr_valid), 32'd0);
            bubbles--;
        end
        if (instr_valid) idle = 0;
        else if (!prev_stall) idle++;
        if (idle > 4) begin
            check("progress", 32'(idle), 32'd4);
            idle = 0;
        end

        stall = s; next_pc_sel = sel; target_pc = tgt;
        #1;
        if (s) check("req_stall", 32'(imem_req), 32'd0);
        if (instr_valid && !s) begin
            check("order", 32'(pc), 32'(exp_pc));
            accepted.push_back(pc);
            if (sel) begin
                exp_pc  = tgt;
                bubbles = 2;
            end else begin
                exp_pc = exp_pc + 16'd4;
            end
        end
        hold_prev  = instr_valid && s;
        hold_pc    = pc;
        hold_ins   = instructions;
        prev_stall = s;
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] wrap_exp[4];
        wrap_exp = '{16'hFFF8, 16'hFFFC, 16'h0000, 16'h0004};
        rst_n = 1'b0; stall = 1'b0; next_pc_sel = 1'b0; target_pc = '0;
        imem_rdata = '0; w_rdata = '0;
        reset_model();
        @(negedge clk);
        @(negedge clk);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_ins", instructions, NOP);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_req", 32'(imem_req), 32'd1);
        check("rst_addr", 32'(imem_addr), 32'd0);

        // T1: reset release, sequential fetch
        rst_n = 1'b1;
        wrap_collect = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t1_addr", 32'(imem_addr), 32'(4 * i));
            check("t1_valid", 32'(instr_valid), (i < 2) ? 32'd0 : 32'd1);
            if (i >= 2) check("t1_pc", 32'(pc), 32'(4 * (i - 2)));
            step(1'b0, 1'b0, 16'h0);
        end

        // T2: stall three cycles while pc=8 is shown
        check("t2_pc", 32'(pc), 32'h8);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0);
        check("t2_held", 32'(pc), 32'h8);
        accepted.delete();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'h0);
        check("t2_n", 32'(accepted.size() >= 3), 32'd1);
        for (int i = 0; i < 3 && i < accepted.size(); i++)
            check("t2_seq", 32'(accepted[i]), 32'(8 + 4 * i));

        // T3: redirect at pc=0x10 after a fresh reset
        rst_n = 1'b0; #1; rst_n = 1'b1;
        reset_model();
        @(negedge clk);
        for (int i = 0; i < 20 && !(instr_valid && pc == 16'h10); i++) step(1'b0, 1'b0, 16'h0);
        check("t3_at", {15'd0, instr_valid, pc}, {15'd0, 1'b1, 16'h10});
        step(1'b0, 1'b1, 16'h40);
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        check("t3_tgt", {15'd0, instr_valid, pc}, {15'd0, 1'b1, 16'h40});
        step(1'b0, 1'b0, 16'h0);
        check("t3_next", {15'd0, instr_valid, pc}, {15'd0, 1'b1, 16'h44});

        // T4: redirect requested while stalled is ignored until stall drops
        step(1'b1, 1'b1, 16'h80);
        step(1'b1, 1'b1, 16'h80);
        check("t4_hold", 32'(pc), 32'h44);
        step(1'b0, 1'b1, 16'h80);
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        check("t4_tgt", {15'd0, instr_valid, pc}, {15'd0, 1'b1, 16'h80});
        step(1'b0, 1'b0, 16'h0);
        check("t4_next", {15'd0, instr_valid, pc}, {15'd0, 1'b1, 16'h84});

        // T5: RESET_PC near the top of the address space wraps
        check("wrap_n", 32'(wrap_pcs.size()), 32'd4);
        for (int i = 0; i < 4 && i < wrap_pcs.size(); i++)
            check("wrap_pc", 32'(wrap_pcs[i]), 32'(wrap_exp[i]));

        // random traffic
        for (int i = 0; i < 1500; i++)
            step(($urandom % 10) < 3, ($urandom % 10) == 0, 16'($urandom) & 16'hFFFC);

        // T6: asynchronous reset with the skid full
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 16'h0);
        stall = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("t6_valid", 32'(instr_valid), 32'd0);
        check("t6_ins", instructions, NOP);
        check("t6_pc", 32'(pc), 32'd0);
        stall = 1'b0;
        #1;
        check("t6_req", 32'(imem_req), 32'd1);
        check("t6_addr", 32'(imem_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        reset_model();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 16'h0);
        check("t6_n", 32'(accepted.size() >= 1), 32'd1);
        if (accepted.size() >= 1) check("t6_first", 32'(accepted[0]), 32'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
